// File: rtl/dmem_responder.sv
// Multi-cycle big-endian word data memory for the MEM stage.
// Define DMEM_ADDR_CHECK_EN to flag misaligned/out-of-range accesses.
module dmem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWre,
    input  logic [31:0] DataAddress,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        AddrErr
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          wr_q;
    logic          rd_q;
    logic [31:0]   dout_q;
    logic          ready_q;
    logic          busy_q;
    logic          err_q;

    logic [7:0] mem_q [DEPTH_BYTES];

    logic          req;
    logic          fire;
    logic          in_idle;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_data;
    logic          acc_wr;
    logic          acc_rd;
    logic          acc_err;
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic [AW-1:0] idx3;

    assign req     = MemRead | MemWre;
    assign in_idle = (state_q == IDLE);

    // With LATENCY 1 the access happens on the acceptance edge itself
    assign fire = (in_idle && req && (LATENCY == 1))
                | ((state_q == BUSY) && (cnt_q == CW'(1)));

    assign acc_addr = in_idle ? DataAddress : addr_q;
    assign acc_data = in_idle ? DataIn : data_q;
    assign acc_wr   = in_idle ? MemWre : wr_q;
    assign acc_rd   = in_idle ? (MemRead & ~MemWre) : rd_q;

    assign idx0 = {acc_addr[AW-1:2], 2'd0};
    assign idx1 = {acc_addr[AW-1:2], 2'd1};
    assign idx2 = {acc_addr[AW-1:2], 2'd2};
    assign idx3 = {acc_addr[AW-1:2], 2'd3};

`ifdef DMEM_ADDR_CHECK_EN
    assign acc_err = (|acc_addr[1:0]) | (acc_addr >= 32'(DEPTH_BYTES));
`else
    logic unused_addr;
    assign unused_addr = ^{acc_addr[31:AW], acc_addr[1:0]};
    assign acc_err     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset && fire && acc_wr && !acc_err) begin
            mem_q[idx0] <= acc_data[31:24];
            mem_q[idx1] <= acc_data[23:16];
            mem_q[idx2] <= acc_data[15:8];
            mem_q[idx3] <= acc_data[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= DataAddress;
                        data_q <= DataIn;
                        wr_q   <= MemWre;
                        rd_q   <= MemRead & ~MemWre;
                        cnt_q  <= CW'(LATENCY - 1);
                        busy_q <= 1'b1;
                        state_q <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (fire) begin
                ready_q <= 1'b1;
                err_q   <= acc_err;
                if (acc_rd) begin
                    dout_q <= acc_err ? 32'h0 :
                        {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};
                end
            end
        end
    end

    assign DataOut  = dout_q;
    assign MemReady = ready_q;
    assign MemBusy  = busy_q;
    assign AddrErr  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 1 and 4.
// Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 4.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_n = 3'b000;
    logic [2:0]  en = 3'b000;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout [3];
    logic [2:0]  rdy;
    logic [2:0]  busy;
    logic [2:0]  err;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int sel = 0;
    bit pend = 0;
    logic [31:0] last;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) u0 (
        .Clk(clk), .Reset(rst_n[0]),
        .MemRead(rd & en[0]), .MemWre(wr & en[0]),
        .DataAddress(addr), .DataIn(din),
        .DataOut(dout[0]), .MemReady(rdy[0]),
        .MemBusy(busy[0]), .AddrErr(err[0])
    );

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(1)) u1 (
        .Clk(clk), .Reset(rst_n[1]),
        .MemRead(rd & en[1]), .MemWre(wr & en[1]),
        .DataAddress(addr), .DataIn(din),
        .DataOut(dout[1]), .MemReady(rdy[1]),
        .MemBusy(busy[1]), .AddrErr(err[1])
    );

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(4)) u2 (
        .Clk(clk), .Reset(rst_n[2]),
        .MemRead(rd & en[2]), .MemWre(wr & en[2]),
        .DataAddress(addr), .DataIn(din),
        .DataOut(dout[2]), .MemReady(rdy[2]),
        .MemBusy(busy[2]), .AddrErr(err[2])
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every MemReady of the selected instance consumes one entry
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy[sel]) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", {31'd0, rdy[sel]}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dataout", dout[sel], e.d);
                    chk("addrerr", {31'd0, err[sel]}, {31'd0, e.e});
                end
            end
        end
    end

    task automatic do_req(int i, logic r, logic w, logic [31:0] a,
                          logic [31:0] d, logic [31:0] ed, logic ee,
                          bit hold);
        int n;
        int lat;
        int bchk;
        exp_t e;
        lat = (i == 0) ? 2 : (i == 1) ? 1 : 4;
        if (!pend) @(negedge clk);
        bchk = pend ? 2 : 1;
        sel = i;
        en = 3'b001 << i;
        rd = r;
        wr = w;
        addr = a;
        din = d;
        e.d = ed;
        e.e = ee;
        q.push_back(e);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == bchk) chk("busy_after_accept", {31'd0, busy[i]}, 32'd1);
        end while (!rdy[i] && n < 20);
        chk("latency", n, lat + (pend ? 1 : 0));
        if (hold) begin
            pend = 1;
        end else begin
            pend = 0;
            @(negedge clk);
            rd = 0;
            wr = 0;
            en = 0;
        end
    endtask

    // Store on instance 2, then reset it k edges after acceptance
    task automatic abort_store(int k, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        sel = 2;
        en = 3'b100;
        wr = 1;
        addr = a;
        din = d;
        repeat (k) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy[2]}, 32'd1);
        chk("abort_ready_before", {31'd0, rdy[2]}, 32'd0);
        rst_n[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, rdy[2]}, 32'd0);
        chk("abort_busy", {31'd0, busy[2]}, 32'd0);
        chk("abort_dout", dout[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        wr = 0;
        en = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 3'b111;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("idle_ready", {29'd0, rdy}, 32'd0);
            chk("idle_busy", {29'd0, busy}, 32'd0);
            chk("idle_err", {29'd0, err}, 32'd0);
            for (int i = 0; i < 3; i++) chk("idle_dout", dout[i], 32'd0);
        end

        do_req(0, 0, 1, 32'h10, 32'h1234_5678, 32'h0, 0, 0);
        chk("mem_byte_10", {24'd0, u0.mem_q[16]}, 32'h12);
        do_req(0, 1, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 0);
        do_req(0, 1, 1, 32'h08, 32'hCAFE_F00D, 32'h1234_5678, 0, 0);
        do_req(0, 1, 0, 32'h08, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef DMEM_ADDR_CHECK_EN
        do_req(0, 1, 0, 32'h13, 32'h0, 32'h0, 1, 0);
        last = 32'h0;
`else
        do_req(0, 1, 0, 32'h13, 32'h0, 32'h1234_5678, 0, 0);
        last = 32'h1234_5678;
`endif
        do_req(0, 0, 1, 32'h04, 32'h0BAD_BEEF, last, 0, 0);
`ifdef DMEM_ADDR_CHECK_EN
        do_req(0, 0, 1, 32'h104, 32'hDEAD_DEAD, last, 1, 0);
        do_req(0, 1, 0, 32'h04, 32'h0, 32'h0BAD_BEEF, 0, 0);
`else
        do_req(0, 0, 1, 32'h104, 32'hDEAD_DEAD, last, 0, 0);
        do_req(0, 1, 0, 32'h04, 32'h0, 32'hDEAD_DEAD, 0, 0);
`endif

        do_req(1, 0, 1, 32'h20, 32'h1111_2222, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h24, 32'h3333_4444, 32'h0, 0, 0);
        do_req(1, 1, 0, 32'h20, 32'h0, 32'h1111_2222, 0, 1);
        do_req(1, 1, 0, 32'h24, 32'h0, 32'h3333_4444, 0, 1);
        do_req(1, 1, 0, 32'h20, 32'h0, 32'h1111_2222, 0, 0);

        do_req(2, 0, 1, 32'h30, 32'hA5A5_0030, 32'h0, 0, 0);
        do_req(2, 0, 1, 32'h34, 32'h5A5A_0034, 32'h0, 0, 0);
        abort_store(2, 32'h30, 32'hFFFF_FFFF);
        do_req(2, 1, 0, 32'h30, 32'h0, 32'hA5A5_0030, 0, 0);
        abort_store(3, 32'h34, 32'hFFFF_FFFF);
        do_req(2, 1, 0, 32'h34, 32'h0, 32'h5A5A_0034, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
